// File: rtl/pc_sequencer_if.sv
// -----------------------------------------------------------------------------
// pc_sequencer_if
//
// Purpose:
//   Groups the program-counter sequencer's bus-level signals:
//     - the incrementer operand and result path,
//     - the fetch valid/ready handshake,
//     - the redirect request and its acknowledge,
//     - the halt request and the halt/overflow status.
//   Clock and reset are not part of this interface. They stay plain module
//   ports.
//
// Signals:
//   inc_a          [31:0]  sequencer -> incrementer operand (copy of PC)
//   inc_answer     [32:0]  incrementer -> sequencer, inc_a + 1 with carry-out
//   fetch_pc       [31:0]  sequencer -> fetch, address offered
//   fetch_valid            sequencer -> fetch, fetch_pc is valid
//   fetch_ready            fetch -> sequencer, fetch accepts fetch_pc
//   redirect_valid         core -> sequencer, branch/jump target present
//   redirect_pc    [31:0]  core -> sequencer, redirect target
//   redirect_ack           sequencer -> core, one-cycle pulse per taken redirect
//   halt_req               core -> sequencer, stop fetching
//   halted                 sequencer -> core, block is in HALT
//   overflow               sequencer -> core, HALT was caused by PC carry-out
//
// Modports:
//   master : the sequencer side
//   slave  : the environment side (incrementer, fetch, core control)
// -----------------------------------------------------------------------------
interface pc_sequencer_if;

    logic [31:0] inc_a;
    logic [32:0] inc_answer;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        halt_req;
    logic        halted;
    logic        overflow;

    modport master (
        output inc_a,
        output fetch_pc,
        output fetch_valid,
        output redirect_ack,
        output halted,
        output overflow,
        input  inc_answer,
        input  fetch_ready,
        input  redirect_valid,
        input  redirect_pc,
        input  halt_req
    );

    modport slave (
        input  inc_a,
        input  fetch_pc,
        input  fetch_valid,
        input  redirect_ack,
        input  halted,
        input  overflow,
        output inc_answer,
        output fetch_ready,
        output redirect_valid,
        output redirect_pc,
        output halt_req
    );

endinterface

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Purpose:
//   Program-counter register stage wrapped around an external 32-bit
//   incrementer. The block does the following:
//     - holds the PC,
//     - drives the PC to the incrementer and takes the sum back as the next
//       sequential PC,
//     - offers the PC to instruction fetch under a valid/ready handshake,
//     - applies branch redirects,
//     - waits through a boot hold after reset,
//     - halts instead of wrapping when the PC carries out of 32 bits.
//
// Parameters:
//   RESET_PC     PC value loaded while reset is asserted.
//   HOLD_CYCLES  Number of cycles after reset release before the first fetch
//                is offered (0..15). A value of 0 behaves like 1: BOOT always
//                lasts at least one cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          pc_sequencer_if.master (incrementer, fetch, redirect, halt)
//   fetch_count  [31:0] saturating count of accepted fetches. This port exists
//                only when the PC_FETCH_COUNT_EN macro is defined.
//
// Configuration macro:
//   PC_FETCH_COUNT_EN  adds the fetch_count output and its counter.
//
// States:
//   BOOT  boot hold. fetch_valid=0. Redirects are still accepted.
//   RUN   fetch_valid=1. The PC advances on each accepted fetch.
//   HALT  fetch_valid=0 and halted=1. The block leaves HALT only on reset.
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_sequencer_if.master       bus
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [31:0]          fetch_count
`endif
);

    // BOOT leaves on the cycle where the hold counter reaches this value.
    // HOLD_CYCLES=0 is clamped so that BOOT still lasts exactly one cycle.
    localparam logic [3:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 4'd0
                                                          : 4'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [3:0]  r_boot_cnt;
    logic [3:0]  w_boot_cnt_next;
    logic        r_redirect_ack;
    logic        w_redirect_ack_next;
    logic        r_overflow;
    logic        w_overflow_next;

    // Decoded handshake terms
    logic        w_fetch_valid;
    logic        w_fetch_fire;
    logic        w_carry;

    assign w_fetch_valid = (r_state == ST_RUN);
    assign w_fetch_fire  = w_fetch_valid && bus.fetch_ready;
    assign w_carry       = bus.inc_answer[32];

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // fetch_valid and halted are decoded from the state register only.
    // overflow and redirect_ack are registered. None of these outputs has
    // a combinational path from an input.
    assign bus.inc_a        = r_pc;
    assign bus.fetch_pc     = r_pc;
    assign bus.fetch_valid  = w_fetch_valid;
    assign bus.halted       = (r_state == ST_HALT);
    assign bus.overflow     = r_overflow;
    assign bus.redirect_ack = r_redirect_ack;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_BOOT;
            r_pc           <= RESET_PC;
            r_boot_cnt     <= 4'd0;
            r_redirect_ack <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_pc           <= w_pc_next;
            r_boot_cnt     <= w_boot_cnt_next;
            r_redirect_ack <= w_redirect_ack_next;
            r_overflow     <= w_overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // Priority in BOOT and RUN, highest first:
    //   1. halt_req
    //   2. redirect
    //   3. accepted fetch (sequential step, or overflow halt on carry)
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        w_pc_next           = r_pc;
        w_boot_cnt_next     = r_boot_cnt;
        w_redirect_ack_next = 1'b0;
        w_overflow_next     = r_overflow;

        case (r_state)
            ST_BOOT: begin
                // The hold counter keeps running even while redirects are
                // taken, so a redirect in BOOT does not shorten the hold.
                w_boot_cnt_next = r_boot_cnt + 4'd1;
                if (r_boot_cnt == HOLD_LAST) begin
                    w_state_next = ST_RUN;
                end

                if (bus.halt_req) begin
                    w_state_next = ST_HALT;
                end else if (bus.redirect_valid) begin
                    w_pc_next           = bus.redirect_pc;
                    w_redirect_ack_next = 1'b1;
                end
            end

            ST_RUN: begin
                if (bus.halt_req) begin
                    w_state_next = ST_HALT;
                end else if (bus.redirect_valid) begin
                    // A redirect wins over an accepted fetch in the same
                    // cycle. The accepted PC still counts as issued, but its
                    // sequential successor is dropped.
                    w_pc_next           = bus.redirect_pc;
                    w_redirect_ack_next = 1'b1;
                end else if (w_fetch_fire) begin
                    if (w_carry) begin
                        // The PC never wraps to 0. It holds at FFFF_FFFF and
                        // the block halts with the sticky overflow flag set.
                        w_overflow_next = 1'b1;
                        w_state_next    = ST_HALT;
                    end else begin
                        w_pc_next = bus.inc_answer[31:0];
                    end
                end
            end

            ST_HALT: begin
                // HALT is terminal until reset. Redirects are ignored here.
            end

            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

`ifdef PC_FETCH_COUNT_EN
    // ------------------------------------------------------------------
    // Accepted-fetch counter. It counts every valid&ready cycle, including
    // cycles where a redirect or an overflow is taken, and saturates at
    // FFFF_FFFF.
    // ------------------------------------------------------------------
    logic [31:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_fetch_fire && (r_fetch_count != 32'hFFFF_FFFF)) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed testbench for pc_sequencer with RESET_PC=0x100 and HOLD_CYCLES=2.
// The bench models the external incrementer as inc_a + 1 with carry-out.
// Inputs are driven 1 time unit after each rising edge, and outputs are
// checked at that same point.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] P_RESET_PC = 32'h0000_0100;
    localparam int          P_HOLD     = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   step;

    pc_sequencer_if u_if ();

`ifdef PC_FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    // Incrementer model
    assign u_if.inc_answer = {1'b0, u_if.inc_a} + 33'd1;

    pc_sequencer #(
        .RESET_PC    (P_RESET_PC),
        .HOLD_CYCLES (P_HOLD)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (u_if.master)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move to 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
        step++;
        $display("step %0d: pc=%h valid=%b ack=%b halted=%b ovf=%b",
                 step, u_if.fetch_pc, u_if.fetch_valid, u_if.redirect_ack,
                 u_if.halted, u_if.overflow);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hr);
        u_if.fetch_ready    = rdy;
        u_if.redirect_valid = rv;
        u_if.redirect_pc    = rpc;
        u_if.halt_req       = hr;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        step   = 0;
        rst_n  = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 1'b0);

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid",    {31'd0, u_if.fetch_valid},  32'd0);
        chk("rst_ack",      {31'd0, u_if.redirect_ack}, 32'd0);
        chk("rst_halted",   {31'd0, u_if.halted},       32'd0);
        chk("rst_ovf",      {31'd0, u_if.overflow},     32'd0);
        chk("rst_pc",       u_if.fetch_pc,              32'h100);
        chk("rst_inc_a",    u_if.inc_a,                 32'h100);
`ifdef PC_FETCH_COUNT_EN
        chk("rst_count",    fetch_count,                32'd0);
`endif

        // ---------------- boot hold then sequential run ----------------
        rst_n = 1'b1;
        tick();
        chk("boot1_valid",  {31'd0, u_if.fetch_valid},  32'd0);
        tick();
        chk("boot2_valid",  {31'd0, u_if.fetch_valid},  32'd1);
        chk("boot2_pc",     u_if.fetch_pc,              32'h100);
        tick();
        chk("seq_pc1",      u_if.fetch_pc,              32'h101);
        tick();
        chk("seq_pc2",      u_if.fetch_pc,              32'h102);

        // ---------------- stall at 0x200 ----------------
        drive(1'b0, 1'b1, 32'h200, 1'b0);
        tick();
        chk("redir200_pc",  u_if.fetch_pc,              32'h200);
        chk("redir200_ack", {31'd0, u_if.redirect_ack}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("stall1_pc",    u_if.fetch_pc,              32'h200);
        chk("stall1_ack",   {31'd0, u_if.redirect_ack}, 32'd0);
        chk("stall1_valid", {31'd0, u_if.fetch_valid},  32'd1);
        tick();
        chk("stall2_pc",    u_if.fetch_pc,              32'h200);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("stall_adv_pc", u_if.fetch_pc,              32'h201);

        // ---------------- redirect beats an accepted fetch, back-to-back ----------------
        drive(1'b0, 1'b1, 32'h300, 1'b0);
        tick();
        chk("r300_pc",      u_if.fetch_pc,              32'h300);
        drive(1'b1, 1'b1, 32'h8000, 1'b0);
        tick();
        chk("r8000_pc",     u_if.fetch_pc,              32'h8000);
        chk("b2b_ack",      {31'd0, u_if.redirect_ack}, 32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ack_drop",     {31'd0, u_if.redirect_ack}, 32'd0);
        chk("r8000_hold",   u_if.fetch_pc,              32'h8000);

        // ---------------- overflow halt ----------------
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        tick();
        chk("rmax_pc",      u_if.fetch_pc,              32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ovf_pc",       u_if.fetch_pc,              32'hFFFF_FFFF);
        chk("ovf_halted",   {31'd0, u_if.halted},       32'd1);
        chk("ovf_flag",     {31'd0, u_if.overflow},     32'd1);
        chk("ovf_valid",    {31'd0, u_if.fetch_valid},  32'd0);
        drive(1'b1, 1'b1, 32'h10, 1'b0);
        tick();
        chk("halt_redir_ack", {31'd0, u_if.redirect_ack}, 32'd0);
        chk("halt_redir_pc",  u_if.fetch_pc,              32'hFFFF_FFFF);
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("ovf_sticky",   {31'd0, u_if.overflow},     32'd1);

        // ---------------- redirect in BOOT, then halt_req beats redirect ----------------
        rst_n = 1'b0;
        #1;
        chk("rst2_ovf",     {31'd0, u_if.overflow},     32'd0);
        chk("rst2_halted",  {31'd0, u_if.halted},       32'd0);
        chk("rst2_pc",      u_if.fetch_pc,              32'h100);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 32'h40, 1'b0);
        tick();
        chk("bootr_pc",     u_if.fetch_pc,              32'h40);
        chk("bootr_ack",    {31'd0, u_if.redirect_ack}, 32'd1);
        chk("bootr_valid",  {31'd0, u_if.fetch_valid},  32'd0);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("bootr_run",    {31'd0, u_if.fetch_valid},  32'd1);
        drive(1'b1, 1'b1, 32'h999, 1'b1);
        tick();
        chk("hreq_halted",  {31'd0, u_if.halted},       32'd1);
        chk("hreq_pc",      u_if.fetch_pc,              32'h40);
        chk("hreq_ovf",     {31'd0, u_if.overflow},     32'd0);
        chk("hreq_ack",     {31'd0, u_if.redirect_ack}, 32'd0);
        chk("hreq_valid",   {31'd0, u_if.fetch_valid},  32'd0);

        // ---------------- asynchronous reset mid-RUN ----------------
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        drive(1'b0, 1'b1, 32'h555, 1'b0);
        tick();
        chk("r555_pc",      u_if.fetch_pc,              32'h555);
        chk("r555_valid",   {31'd0, u_if.fetch_valid},  32'd1);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",   {31'd0, u_if.fetch_valid},  32'd0);
        chk("arst_ack",     {31'd0, u_if.redirect_ack}, 32'd0);
        chk("arst_pc",      u_if.fetch_pc,              32'h100);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        chk("reboot_valid", {31'd0, u_if.fetch_valid},  32'd0);
        tick();
        chk("reboot_pc",    u_if.fetch_pc,              32'h100);
`ifdef PC_FETCH_COUNT_EN
        chk("cnt_zero",     fetch_count,                32'd0);
`endif
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("five_pc",      u_if.fetch_pc,              32'h105);
`ifdef PC_FETCH_COUNT_EN
        chk("cnt_five",     fetch_count,                32'd5);
`endif
        tick();
        chk("five_hold",    u_if.fetch_pc,              32'h105);
`ifdef PC_FETCH_COUNT_EN
        chk("cnt_hold",     fetch_count,                32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
